// File: rtl/uart_tx_sched_pkg.sv
// Shared UART definitions: scheduler state encoding, frame-config field
// positions and the default launch timeout.
package uart_tx_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  // Frame config word: {stop_sel, parity_en, parity_even, data_len[1:0]}
  localparam int CFG_W       = 5;
  localparam int CFG_STOP    = 4;
  localparam int CFG_PEN     = 3;
  localparam int CFG_PEVEN   = 2;
  localparam int CFG_LEN_MSB = 1;
  localparam int CFG_LEN_LSB = 0;

  localparam int DEFAULT_TIMEOUT = 64;

  // Grant index width covers the largest supported requester count
  localparam int GNT_W   = 3;
  localparam int MAX_REQ = 8;

  // Total line bits of one frame: start + (5+len) data + optional parity + 1/2 stop
  function automatic int cfg_frame_bits(input logic [CFG_W-1:0] cfg);
    return 1 + 5 + int'(cfg[CFG_LEN_MSB:CFG_LEN_LSB])
         + (cfg[CFG_PEN] ? 1 : 0) + (cfg[CFG_STOP] ? 2 : 1);
  endfunction

  // Parity bit for a frame: even parity makes the total count of ones even
  function automatic logic cfg_parity_bit(input logic [7:0] data,
                                          input logic [CFG_W-1:0] cfg);
    return cfg[CFG_PEVEN] ? ^data : ~^data;
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// Round-robin pick: first set request at or above ptr, else the first set
// request below ptr (wrap-around). Purely combinational.
module uart_tx_sched_rr_pick
  import uart_tx_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [GNT_W-1:0] ptr_i,
  output logic [GNT_W-1:0] idx_o,
  output logic             vld_o
);

  // Two descending scans so the lowest index wins; the upper region overrides the wrapped one
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i] && (i < int'(ptr_i))) begin
        idx_o = GNT_W'(i);
        vld_o = 1'b1;
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i] && (i >= int'(ptr_i))) begin
        idx_o = GNT_W'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: arbitrates NREQ requesters round-robin onto one
// UART core, launches each frame, and reports completion (ack) or a launch
// timeout (err) back to the granted requester.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [8*NREQ-1:0]     req_data,
  input  logic [CFG_W*NREQ-1:0] req_cfg,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       err,
  output logic                  tx_req,
  output logic [7:0]            tx_data,
  output logic [CFG_W-1:0]      tx_cfg,
  input  logic                  tx_busy,
  output logic [GNT_W-1:0]      gnt_id,
  output logic                  sched_busy
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMER_MAX = '1;

  state_e            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [GNT_W-1:0]  ptr_q, ptr_d;
  logic [GNT_W-1:0]  gnt_q, gnt_d;
  logic [7:0]        data_q, data_d;
  logic [CFG_W-1:0]  cfg_q, cfg_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [NREQ-1:0]   err_q, err_d;

  logic [GNT_W-1:0]  pick_idx;
  logic              pick_vld;
  logic [GNT_W-1:0]  next_ptr;
  logic              pulse_now;

  // Per-requester slices padded to MAX_REQ so a 3-bit grant index addresses them exactly
  logic [7:0]        data_arr [MAX_REQ];
  logic [CFG_W-1:0]  cfg_arr  [MAX_REQ];

  for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_slice
    if (gi < NREQ) begin : g_used
      assign data_arr[gi] = req_data[8*gi +: 8];
      assign cfg_arr[gi]  = req_cfg[CFG_W*gi +: CFG_W];
    end else begin : g_pad
      assign data_arr[gi] = '0;
      assign cfg_arr[gi]  = '0;
    end
  end

  uart_tx_sched_rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  // Pointer moves just past the finished grant, wrapping at NREQ-1
  assign next_ptr  = (gnt_q == GNT_W'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
  // While an ack/err is on the wires the block stays idle one extra cycle
  assign pulse_now = (|ack_q) | (|err_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    cfg_d   = cfg_q;
    ack_d   = '0;
    err_d   = '0;
    unique case (state_q)
      ST_IDLE: begin
        // A busy core in IDLE is a foreign frame: hold off granting
        if (pick_vld && !tx_busy && !pulse_now) begin
          gnt_d   = pick_idx;
          data_d  = data_arr[pick_idx];
          cfg_d   = cfg_arr[pick_idx];
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        timer_d = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else begin
          if (timer_q != TIMER_MAX) begin
            timer_d = timer_q + TW'(1);
          end
          // err is registered, so fire when the incremented count hits TIMEOUT-1
          if (int'(timer_q) + 1 >= TIMEOUT - 1) begin
            err_d   = NREQ'(1) << gnt_q;
            ptr_d   = next_ptr;
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          ack_d   = NREQ'(1) << gnt_q;
          ptr_d   = next_ptr;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
      cfg_q   <= '0;
      ack_q   <= '0;
      err_q   <= '0;
    end else begin
      timer_q <= timer_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      cfg_q   <= cfg_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Moore outputs decoded from the current state
  always_comb begin
    tx_req     = (state_q == ST_LAUNCH);
    sched_busy = (state_q != ST_IDLE);
  end

  assign ack     = ack_q;
  assign err     = err_q;
  assign tx_data = data_q;
  assign tx_cfg  = cfg_q;
  assign gnt_id  = gnt_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: transaction-level reference model plus directed
// scenarios and a randomized traffic phase.
module tb_uart_tx_sched;

  localparam int N  = 4;
  localparam int TO = 64;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [5*N-1:0] req_cfg;
  logic [N-1:0]   ack;
  logic [N-1:0]   err;
  logic           tx_req;
  logic [7:0]     tx_data;
  logic [4:0]     tx_cfg;
  logic           tx_busy;
  logic [2:0]     gnt_id;
  logic           sched_busy;

  uart_tx_sched #(.NREQ(N), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_data   (req_data),
    .req_cfg    (req_cfg),
    .ack        (ack),
    .err        (err),
    .tx_req     (tx_req),
    .tx_data    (tx_data),
    .tx_cfg     (tx_cfg),
    .tx_busy    (tx_busy),
    .gnt_id     (gnt_id),
    .sched_busy (sched_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_on   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit         m_frame;      // a frame is granted and not yet finished
  int         m_age;        // cycles since its tx_req cycle
  bit         m_busy_seen;  // core has accepted the frame
  int         m_g, m_ptr;
  logic [7:0] m_data;
  logic [4:0] m_cfg;
  logic [N-1:0] m_ack, m_err;

  function automatic int rr(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (((r >> ((p + k) % N)) & N'(1)) != '0) return (p + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_frame = 0; m_age = 0; m_busy_seen = 0; m_g = 0; m_ptr = 0;
      m_data = '0; m_cfg = '0; m_ack = '0; m_err = '0;
    end else begin
      logic [N-1:0] na, ne;
      na = '0;
      ne = '0;
      if (m_frame) begin
        if (m_age == 0) begin
          m_age = 1;
        end else if (!m_busy_seen) begin
          if (tx_busy) m_busy_seen = 1;
          else if (m_age + 1 == TO) begin
            ne = N'(1) << m_g; m_ptr = (m_g + 1) % N; m_frame = 0;
          end
          m_age++;
        end else if (!tx_busy) begin
          na = N'(1) << m_g; m_ptr = (m_g + 1) % N; m_frame = 0;
        end
      end else if (m_ack == '0 && m_err == '0 && !tx_busy && req != '0) begin
        m_g = rr(req, m_ptr);
        m_data = 8'(req_data >> (8 * m_g));
        m_cfg  = 5'(req_cfg >> (5 * m_g));
        m_frame = 1; m_age = 0; m_busy_seen = 0;
      end
      m_ack = na;
      m_err = ne;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("ack", 32'(ack), 32'(m_ack));
      chk("err", 32'(err), 32'(m_err));
      chk("tx_req", 32'(tx_req), 32'(m_frame && m_age == 0));
      chk("sched_busy", 32'(sched_busy), 32'(m_frame));
      chk("gnt_id", 32'(gnt_id), 32'(m_g));
      chk("tx_data", 32'(tx_data), 32'(m_data));
      chk("tx_cfg", 32'(tx_cfg), 32'(m_cfg));
      chk("ack_err_onehot", 32'($countones({ack, err}) <= 1), 32'd1);
    end
  end

  // ---------------- stimulus: requesters and core emulation ----------------
  bit core_en = 0, core_rand = 0, rand_mode = 0;
  int fix_d = 1, fix_len = 1, c_start = 0, c_len = 0, n_done = 0;

  task automatic core_tick();
    if (c_start > 0) begin
      c_start--;
      if (c_start == 0) tx_busy = 1'b1;
    end else if (tx_busy && c_len > 0) begin
      c_len--;
      if (c_len == 0) tx_busy = 1'b0;
    end
    if (tx_req) begin
      int d, l;
      if (core_rand) begin
        d = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 3));
        l = int'($urandom_range(1, 6));
      end else begin
        d = fix_d; l = fix_len;
      end
      if (d > 0) begin c_start = d; c_len = l; end
    end else if (core_rand && !sched_busy && !tx_busy && c_start == 0 &&
                 $urandom_range(0, 39) == 0) begin
      c_start = 1; c_len = int'($urandom_range(1, 4));
    end
  endtask

  task automatic rand_reqs();
    for (int i = 0; i < N; i++) begin
      if (ack[i] || err[i]) begin
        req[i] = 1'b0;
        n_done++;
      end else if (!req[i]) begin
        if ($urandom_range(0, 5) == 0) begin
          req[i] = 1'b1;
          req_data[8*i +: 8] = 8'($urandom);
          req_cfg[5*i +: 5]  = 5'($urandom);
        end
      end else begin
        if ($urandom_range(0, 7) == 0) req_data[8*i +: 8] = 8'($urandom);
        if ($urandom_range(0, 7) == 0) req_cfg[5*i +: 5]  = 5'($urandom);
        if (sched_busy && gnt_id == 3'(i) && $urandom_range(0, 30) == 0) req[i] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    cyc++;
    if (rand_mode) rand_reqs();
    if (core_en) core_tick();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0; req = '0; tx_busy = 0; c_start = 0; c_len = 0;
    step(); step();
    rst_n = 1;
  endtask

  task automatic wait_txreq(input int bound, output bit ok);
    ok = 0;
    for (int k = 0; k < bound; k++) begin
      if (tx_req) begin ok = 1; break; end
      step();
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL wait_tx_req: got no launch, expected one within %0d cycles", bound);
    end
  endtask

  task automatic wait_pulse(input int bound, output bit ok);
    ok = 0;
    for (int k = 0; k < bound; k++) begin
      if ((ack | err) != '0) begin ok = 1; break; end
      step();
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL wait_pulse: got no ack/err, expected one within %0d cycles", bound);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, saw;
    int t_l, last_ack;
    rst_n = 1; req = '0; req_data = '0; req_cfg = '0; tx_busy = 0;
    #1 rst_n = 0;
    chk_on = 1;
    #1;
    chk("rst_tx_req", 32'(tx_req), 32'd0);
    chk("rst_sched_busy", 32'(sched_busy), 32'd0);
    chk("rst_ack_err", 32'({ack, err}), 32'd0);
    chk("rst_gnt_data_cfg", 32'({gnt_id, tx_data, tx_cfg}), 32'd0);
    step(); step();
    rst_n = 1;

    // Single request
    do_reset();
    core_en = 1; core_rand = 0; fix_d = 1; fix_len = 40;
    req = 4'b0001; req_data[7:0] = 8'hA5; req_cfg[4:0] = 5'b00011;
    wait_txreq(10, ok);
    t_l = cyc;
    chk("t1_tx_data", 32'(tx_data), 32'hA5);
    chk("t1_tx_cfg", 32'(tx_cfg), 32'b00011);
    chk("t1_gnt", 32'(gnt_id), 32'd0);
    step();
    chk("t1_single_strobe", 32'(tx_req), 32'd0);
    wait_pulse(60, ok);
    chk("t1_ack", 32'(ack), 32'b0001);
    chk("t1_ack_latency", 32'(cyc - t_l), 32'd42);
    req = '0;

    // Contention: all four held
    do_reset();
    fix_d = 1; fix_len = 3;
    req = 4'b1111;
    last_ack = 0;
    for (int n = 0; n < 5; n++) begin
      wait_txreq(20, ok);
      chk("t2_order", 32'(gnt_id), 32'(n % 4));
      if (n > 0) chk("t2_gap", 32'(cyc - last_ack), 32'd2);
      step();
      wait_pulse(20, ok);
      chk("t2_ack", 32'(ack), 32'(1 << (n % 4)));
      last_ack = cyc;
    end
    req = '0;

    // Timeout with core never busy
    do_reset();
    core_en = 0; tx_busy = 0;
    req = 4'b0100;
    wait_txreq(10, ok);
    t_l = cyc;
    saw = 0;
    step();
    for (int k = 0; k < 80; k++) begin
      if (ack != '0) saw = 1;
      if (err != '0) break;
      step();
    end
    chk("t3_err", 32'(err), 32'b0100);
    chk("t3_err_latency", 32'(cyc - t_l), 32'd64);
    chk("t3_no_ack", 32'(saw), 32'd0);
    req = 4'b1101;
    wait_txreq(5, ok);
    chk("t3_ptr_after_err", 32'(gnt_id), 32'd3);
    req = '0;

    // Latched data immune to source changes
    do_reset();
    core_en = 1; fix_d = 1; fix_len = 5;
    req = 4'b0010; req_data[15:8] = 8'h3C;
    wait_txreq(10, ok);
    req_data[15:8] = 8'hFF;
    for (int k = 0; k < 20 && ack == '0; k++) begin
      chk("t4_hold", 32'(tx_data), 32'h3C);
      step();
    end
    chk("t4_ack", 32'(ack), 32'b0010);
    chk("t4_data_at_ack", 32'(tx_data), 32'h3C);
    req = '0;

    // Reset in WAIT_DONE
    do_reset();
    fix_d = 1; fix_len = 30;
    req = 4'b0010;
    wait_txreq(10, ok);
    step(); step(); step(); step();
    chk("t5_busy_before_rst", 32'(sched_busy), 32'd1);
    #2 rst_n = 0;
    #1;
    chk("t5_outs_zero", 32'({tx_req, sched_busy, ack, err, gnt_id}), 32'd0);
    chk("t5_data_cfg_zero", 32'({tx_data, tx_cfg}), 32'd0);
    step(); step();
    rst_n = 1;
    saw = 0; ok = 0;
    for (int k = 0; k < 60; k++) begin
      if ((ack | err) != '0) saw = 1;
      if (tx_req) begin ok = 1; break; end
      step();
    end
    chk("t5_relaunch", 32'(ok), 32'd1);
    chk("t5_no_pulse", 32'(saw), 32'd0);
    chk("t5_gnt", 32'(gnt_id), 32'd1);
    req = '0;

    // Foreign busy blocks granting
    do_reset();
    core_en = 0; tx_busy = 1;
    req = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t6_blocked", 32'({tx_req, sched_busy}), 32'd0);
    end
    tx_busy = 0;
    chk("t6_no_launch_yet", 32'(tx_req), 32'd0);
    step();
    chk("t6_launch", 32'(tx_req), 32'd1);
    req = '0;

    // Randomized traffic against the model
    do_reset();
    core_en = 1; core_rand = 1; rand_mode = 1; n_done = 0;
    repeat (4000) step();
    rand_mode = 0; req = '0;
    repeat (200) step();
    chk("rand_activity", 32'(n_done > 20), 32'd1);

    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
